// File: rtl/encoder_pkg.sv
// Shared constants, state type and reference helper for the sequential 8-to-3 encoder.
// The package constants N and W are the defaults for the encoder's parameters.
package encoder_pkg;

    parameter int unsigned N = 8;
    parameter int unsigned W = 3;

    typedef enum logic [0:0] {
        IDLE,
        SCAN
    } state_e;

    // Index of the lowest set bit; returns 0 for an all-zero vector.
    function automatic logic [W-1:0] lowest_set_index(input logic [N-1:0] vec);
        logic [W-1:0] idx;
        idx = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/lowest_bit_enc.sv
// Combinational priority encoder: index of the lowest set bit of vec_i,
// plus flags for "any bit set" and "exactly one bit set".
module lowest_bit_enc #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 3
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] idx_o,
    output logic         found_o,
    output logic         single_o
);

    logic [N-1:0] rest;

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        // Walk from the top so the lowest set bit is the one that sticks.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = W'(i);
                found_o = 1'b1;
            end
        end
    end

    // Clearing the lowest set bit leaves zero exactly when popcount is one.
    assign rest     = vec_i & (vec_i - 1'b1);
    assign single_o = found_o && (rest == '0);

endmodule

// File: rtl/encoder_8to3_scan.sv
// Sequential 8-to-3 encoder: accepts a request vector and emits the index of
// every set bit, lowest first, one per output handshake, flagging the final one.
module encoder_8to3_scan
    import encoder_pkg::*;
#(
    parameter int unsigned N = encoder_pkg::N,
    parameter int unsigned W = encoder_pkg::W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] d,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         last,
    output logic         zero,
    output logic         busy
);

    state_e       state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic         zero_q, zero_d;

    logic [W-1:0] low_idx;
    logic         low_found;
    logic         low_single;

    logic         accept;
    logic         handshake;

    lowest_bit_enc #(
        .N (N),
        .W (W)
    ) u_lowest_bit_enc (
        .vec_i    (pending_q),
        .idx_o    (low_idx),
        .found_o  (low_found),
        .single_o (low_single)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == SCAN);
    assign busy      = out_valid;
    assign zero      = zero_q;

    // Index outputs follow pending directly; forced to zero outside a scan.
    assign y    = (out_valid && low_found) ? low_idx : '0;
    assign last = out_valid && low_single;

    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        zero_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (d != '0) begin
                        pending_d = d;
                        state_d   = SCAN;
                    end else begin
                        zero_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                // New vectors on d are ignored here; in_ready is low.
                if (handshake) begin
                    pending_d = pending_q & (pending_q - 1'b1);
                    if (low_single) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            zero_q    <= zero_d;
        end
    end

endmodule

// File: tb/tb_encoder_8to3_scan.sv
// Directed self-checking bench for encoder_8to3_scan.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_encoder_8to3_scan;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] d;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] y;
    logic       last;
    logic       zero;
    logic       busy;

    int n_tests;
    int n_fail;

    encoder_8to3_scan dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .last      (last),
        .zero      (zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] acc;
        logic [2:0] held_y;
        int         cnt;
        int         guard;

        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        d         = '0;

        // Reset state
        step();
        step();
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_y", 32'(y), 32'd0);
        check_eq("rst_last", 32'(last), 32'd0);
        check_eq("rst_zero", 32'(zero), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step();

        // 1: asynchronous reset in the middle of scanning 8'hFF
        in_valid = 1'b1;
        d        = 8'hFF;
        step();
        in_valid = 1'b0;
        check_eq("t1_scan_started", 32'(out_valid), 32'd1);
        step();
        check_eq("t1_held_y", 32'(y), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t1_async_out_valid", 32'(out_valid), 32'd0);
        check_eq("t1_async_in_ready", 32'(in_ready), 32'd1);
        check_eq("t1_async_busy", 32'(busy), 32'd0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        d         = 8'h10;
        step();
        in_valid = 1'b0;
        check_eq("t1_after_rst_y", 32'(y), 32'd4);
        check_eq("t1_after_rst_last", 32'(last), 32'd1);
        step();
        check_eq("t1_after_rst_idle", 32'(in_ready), 32'd1);

        // 2: single bit, latency 1
        in_valid = 1'b1;
        d        = 8'b0000_0100;
        step();
        in_valid = 1'b0;
        check_eq("t2_out_valid", 32'(out_valid), 32'd1);
        check_eq("t2_y", 32'(y), 32'd2);
        check_eq("t2_last", 32'(last), 32'd1);
        check_eq("t2_in_ready_low", 32'(in_ready), 32'd0);
        step();
        check_eq("t2_in_ready_back", 32'(in_ready), 32'd1);
        check_eq("t2_out_valid_done", 32'(out_valid), 32'd0);

        // 3: 8'b1010_0001 -> 0, 5, 7 on consecutive cycles
        in_valid = 1'b1;
        d        = 8'b1010_0001;
        step();
        in_valid = 1'b0;
        check_eq("t3_y0", 32'(y), 32'd0);
        check_eq("t3_last0", 32'(last), 32'd0);
        check_eq("t3_rdy0", 32'(in_ready), 32'd0);
        step();
        check_eq("t3_y1", 32'(y), 32'd5);
        check_eq("t3_last1", 32'(last), 32'd0);
        check_eq("t3_rdy1", 32'(in_ready), 32'd0);
        step();
        check_eq("t3_y2", 32'(y), 32'd7);
        check_eq("t3_last2", 32'(last), 32'd1);
        check_eq("t3_rdy2", 32'(in_ready), 32'd0);
        step();
        check_eq("t3_rdy_back", 32'(in_ready), 32'd1);
        check_eq("t3_ovalid_done", 32'(out_valid), 32'd0);

        // 4: 8'hFF with backpressure on alternate cycles; 16 scan cycles
        in_valid = 1'b1;
        d        = 8'hFF;
        step();
        in_valid = 1'b0;
        acc      = '0;
        cnt      = 0;
        guard    = 0;
        held_y   = '0;
        while (out_valid && guard < 40) begin
            check_eq($sformatf("t4_y_c%0d", cnt), 32'(y), 32'(cnt / 2));
            check_eq($sformatf("t4_last_c%0d", cnt), 32'(last), 32'((cnt / 2) == 7));
            if (cnt % 2 == 1) begin
                check_eq($sformatf("t4_hold_c%0d", cnt), 32'(y), 32'(held_y));
                acc = acc | (8'd1 << y);
            end
            held_y    = y;
            out_ready = (cnt % 2 == 1);
            cnt++;
            guard++;
            step();
        end
        check_eq("t4_scan_cycles", 32'(cnt), 32'd16);
        check_eq("t4_roundtrip", 32'(acc), 32'hFF);
        out_ready = 1'b1;

        // 5: all-zero vector
        in_valid = 1'b1;
        d        = 8'h00;
        step();
        in_valid = 1'b0;
        check_eq("t5_zero_pulse", 32'(zero), 32'd1);
        check_eq("t5_out_valid", 32'(out_valid), 32'd0);
        check_eq("t5_in_ready", 32'(in_ready), 32'd1);
        step();
        check_eq("t5_zero_clear", 32'(zero), 32'd0);
        check_eq("t5_out_valid2", 32'(out_valid), 32'd0);

        // 6: in_valid held high with d changing during the scan of 8'b0100_1000
        in_valid = 1'b1;
        d        = 8'b0100_1000;
        acc      = '0;
        step();
        d = 8'hFF;
        check_eq("t6_y0", 32'(y), 32'd3);
        check_eq("t6_last0", 32'(last), 32'd0);
        acc = acc | (8'd1 << y);
        step();
        d = 8'h02;
        check_eq("t6_y1", 32'(y), 32'd6);
        check_eq("t6_last1", 32'(last), 32'd1);
        acc = acc | (8'd1 << y);
        check_eq("t6_roundtrip", 32'(acc), 32'h48);
        step();
        check_eq("t6_gap_out_valid", 32'(out_valid), 32'd0);
        check_eq("t6_gap_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check_eq("t6_next_y", 32'(y), 32'd1);
        check_eq("t6_next_last", 32'(last), 32'd1);
        step();
        check_eq("t6_final_idle", 32'(in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/encoder_8to3_scan.md
Name: encoder_8to3_scan

Overview:
Sequential 8-to-3 encoder; the inverse of the team's 3-to-8 decoder. It accepts an 8-bit request/one-hot-style vector on a valid/ready input handshake. It then emits the 3-bit index of every set bit, lowest first, one index per output handshake, with a last flag. It sits between request-vector producers (arbiters, interrupt/flag registers) and index consumers, including the 3-to-8 decoder for round-trip reconstruction.

Parameters:
N, 8, input vector width
W, 3, index width; must equal clog2(N)

Ports:
clk  input  1  rising-edge clock, single clock domain
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  producer has vector on d
in_ready  output  1  block can accept a vector
d  input  N  request vector
out_valid  output  1  y holds a valid index
out_ready  input  1  consumer accepts y
y  output  W  index of lowest remaining set bit
last  output  1  y is the final set bit of the current vector
zero  output  1  one-cycle pulse: an all-zero vector was accepted
busy  output  1  scan in progress, equal to out_valid

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (async, immediate on rst_n low):
  - state=IDLE, pending=0, zero=0.
  - Outputs: out_valid=0, y=0, last=0, busy=0, in_ready=1.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SCAN: in_ready=0, out_valid=1.
- IDLE, accept (in_valid & in_ready at a clk edge):
  - d!=0: pending<=d, state<=SCAN. out_valid is high on the cycle after accept (latency 1).
  - d==0: zero<=1 for exactly one cycle, state stays IDLE, out_valid never rises.
- SCAN outputs, combinational from pending:
  - y = index of lowest set bit.
  - last = exactly one bit of pending set.
- SCAN output handshake (out_valid & out_ready at a clk edge):
  - Clear bit y in pending.
  - If last: state<=IDLE, in_ready=1 on the next cycle.
- Back-to-back: no accept in the same cycle as the last handshake. Cost per vector = popcount(d)+1 cycles with out_ready held high.
- Backpressure: while out_valid & !out_ready, y, last and pending are held stable. No skipped or duplicated indices.
- in_valid/d while in SCAN: ignored; the captured vector is unaffected.
- Ordering: indices strictly ascending. y=7 is always last when bit 7 is set.
- Width rule: y is exactly W bits. No out-of-range index is possible because pending!=0 whenever out_valid=1.
- Reset mid-scan: out_valid drops and in_ready rises asynchronously. The partial vector is discarded; no completion indication.
- Invariant for the bench: OR over the 3-to-8 decoding of all y of one vector equals d.

Decomposition:
- Package encoder_pkg holds:
  - constants N=8, W=3;
  - state enum {IDLE, SCAN};
  - function lowest_set_index(vector) for bench reference.
- One combinational sub-module, lowest_bit_enc:
  - input N-bit vector;
  - outputs W-bit index, found flag, single-bit flag (popcount==1).
- The FSM, pending register and handshake logic stay in encoder_8to3_scan.

Test Plan:
1. rst_n=0 asserted mid-scan of d=8'hFF -> out_valid=0, in_ready=1 without waiting for clk. After release, the next accept works normally.
2. d=8'b0000_0100, out_ready=1 -> the cycle after accept: out_valid=1, y=2, last=1. The following cycle: in_ready=1, out_valid=0.
3. d=8'b1010_0001, out_ready=1 -> y=0,5,7 on 3 consecutive cycles. last=1 only with y=7. in_ready low for exactly those 3 cycles.
4. d=8'hFF, out_ready toggling 1,0,1,0... -> y=0..7 each exactly once, held stable during out_ready=0. last with y=7 only. 16 scan cycles.
5. d=8'h00 accepted -> zero=1 for one cycle, out_valid stays 0, in_ready stays 1.
6. in_valid held high with d changing during the scan of 8'b0100_1000 -> outputs are only y=3, then y=6 (last). The next vector is accepted only on the cycle after the last handshake. The decoder round-trip OR equals 8'b0100_1000.
